// File: rtl/mul_div_unit.sv
// Sequential 16x16 multiply (signed Booth radix-2) / divide (unsigned restoring) unit; 18 cycles per op, 2 on divide-by-zero.
// No backpressure: start is taken only in IDLE and ignored while busy; done/wr_en pulse for exactly one cycle.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             wr_en_hi,
  output logic             wr_en_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_booth_hi;
  logic [WIDTH-1:0] w_booth_lo;

  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_neg;
  logic [WIDTH:0]   w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  logic [WIDTH:0]   w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_div_zero = op && (b_in == '0);
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST_ITER);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_ITER) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    wr_en_hi = 1'b0;
    wr_en_lo = 1'b0;
    case (r_state)
      S_RUN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        wr_en_hi = 1'b1;
        wr_en_lo = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;
  assign dbz       = r_dbz;

  // Booth step: A is one bit wider than the operand so a - (-2^(W-1)) cannot overflow.
  assign w_a_ext = {r_a[WIDTH-1], r_a};

  always_comb begin
    w_booth_sum = r_acc_hi;
    case ({r_acc_lo[0], r_qm1})
      2'b01:   w_booth_sum = r_acc_hi + w_a_ext;
      2'b10:   w_booth_sum = r_acc_hi - w_a_ext;
      default: w_booth_sum = r_acc_hi;
    endcase
  end

  assign w_booth_hi = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
  assign w_booth_lo = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};

  // Restoring step: R < b always holds, so the shifted remainder fits WIDTH+1 bits
  // and the top bit of the WIDTH+1-bit difference is a reliable borrow.
  assign w_div_sh   = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_neg  = w_div_diff[WIDTH];
  assign w_div_hi   = w_div_neg ? w_div_sh : w_div_diff;
  assign w_div_lo   = {r_acc_lo[WIDTH-2:0], ~w_div_neg};

  assign w_iter_hi = r_op ? w_div_hi : w_booth_hi;
  assign w_iter_lo = r_op ? w_div_lo : w_booth_lo;

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_a      <= a_in;
      r_b      <= b_in;
      r_acc_hi <= '0;
      r_acc_lo <= op ? a_in : b_in;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_dbz    <= w_div_zero;
      if (w_div_zero) begin
        r_res_hi <= a_in;
        r_res_lo <= '1;
      end
    end else if (r_state == S_RUN) begin
      r_acc_hi <= w_iter_hi;
      r_acc_lo <= w_iter_lo;
      r_qm1    <= r_acc_lo[0];
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_res_hi <= w_iter_hi[WIDTH-1:0];
        r_res_lo <= w_iter_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: table of operations plus hand-written
// sequences for ignored restart, mid-operation reset and back-to-back streaming.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [15:0] result_hi;
  logic [15:0] result_lo;
  logic        wr_en_hi;
  logic        wr_en_lo;

  int n_pass;
  int n_total;

  mul_div_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .wr_en_hi  (wr_en_hi),
    .wr_en_lo  (wr_en_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one op in the current cycle (cycle k) and wait for done; lat counts cycles after k.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    op    = v.op;
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    chk($sformatf("v%0d busy_at_accept", idx), {31'd0, busy}, 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        chk($sformatf("v%0d busy_after_accept", idx), {31'd0, busy}, 32'd1);
      end
    end while (!done && lat < 40);
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d result", idx), {result_hi, result_lo}, {v.hi, v.lo});
    chk($sformatf("v%0d dbz", idx), {31'd0, dbz}, {31'd0, v.dbz});
    chk($sformatf("v%0d wr_en", idx), {30'd0, wr_en_hi, wr_en_lo}, 32'd3);
    @(negedge clk);
    chk($sformatf("v%0d done_width", idx), {30'd0, done, wr_en_hi | wr_en_lo}, 32'd0);
    chk($sformatf("v%0d busy_idle", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d result_held", idx), {result_hi, result_lo}, {v.hi, v.lo});
  endtask

  initial begin
    int lat;
    int cnt;
    int t1, t2, t3, nd, wide;
    logic prev;

    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{1'b0, 16'h0003, 16'hFFFC, 16'hFFFF, 16'hFFF4, 1'b0, 17};
    vecs[1]  = '{1'b0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 17};
    vecs[2]  = '{1'b0, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8001, 1'b0, 17};
    vecs[3]  = '{1'b1, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0, 17};
    vecs[4]  = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
    vecs[5]  = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};
    vecs[6]  = '{1'b1, 16'h0010, 16'h0003, 16'h0001, 16'h0005, 1'b0, 17};
    vecs[7]  = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
    vecs[9]  = '{1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000, 1'b0, 17};
    vecs[10] = '{1'b0, 16'h0100, 16'h0100, 16'h0001, 16'h0000, 1'b0, 17};
    vecs[11] = '{1'b0, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 1'b0, 17};
    vecs[12] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 17};
    vecs[13] = '{1'b1, 16'h8000, 16'h8001, 16'h8000, 16'h0000, 1'b0, 17};

    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {28'd0, busy, done, wr_en_hi, wr_en_lo}, 32'd0);
    chk("reset_result", {result_hi, result_lo}, 32'd0);
    chk("reset_dbz", {31'd0, dbz}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    // A second start while busy must be ignored; the first op finishes untouched.
    @(negedge clk);
    op = 1'b0; a_in = 16'h0003; b_in = 16'hFFFC; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == 5);
      if (lat == 5) begin
        op = 1'b1; a_in = 16'h0007; b_in = 16'h0009;
      end
    end while (!done && lat < 40);
    chk("restart_latency", 32'(lat), 32'd17);
    chk("restart_result", {result_hi, result_lo}, 32'hFFFF_FFF4);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("restart_no_extra_done", 32'(cnt), 32'd0);

    // Reset in cycle k+8 abandons the op without any write pulse.
    @(negedge clk);
    op = 1'b0; a_in = 16'h0100; b_in = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctrl", {28'd0, busy, done, wr_en_hi, wr_en_lo}, 32'd0);
    chk("midrst_result", {result_hi, result_lo}, 32'd0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || wr_en_hi || wr_en_lo) cnt++;
    end
    chk("midrst_no_pulse", 32'(cnt), 32'd0);

    // Continuous start: one accept every 18 cycles, done pulses one cycle wide.
    @(negedge clk);
    op = 1'b0; a_in = 16'h0005; b_in = 16'h0006; start = 1'b1;
    t1 = 0; t2 = 0; t3 = 0; nd = 0; wide = 0; prev = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) t1 = c;
        if (nd == 2) t2 = c;
        if (nd == 3) t3 = c;
        chk($sformatf("stream_result%0d", nd), {result_hi, result_lo}, 32'h0000_001E);
      end
      if (done && prev) wide++;
      prev = done;
    end
    start = 1'b0;
    chk("stream_count", 32'(nd), 32'd3);
    chk("stream_first", 32'(t1), 32'd17);
    chk("stream_gap1", 32'(t2 - t1), 32'd18);
    chk("stream_gap2", 32'(t3 - t2), 32'd18);
    chk("stream_width", 32'(wide), 32'd0);
    repeat (25) @(negedge clk);
    chk("stream_drained", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
